// File: rtl/core_prefetch.sv
// Instruction prefetch queue: sequential word fetches to the MMU insn port, buffered
// with their PCs for decode, and redirected (queue and in-flight fetch dropped) on flush.
module core_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [29:0] RESET_PC = 30'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [29:0] target,
    output logic        insn_start,
    output logic [29:0] insn_addr,
    input  logic        insn_ready,
    input  logic [31:0] insn_data_rd,
    output logic        out_valid,
    output logic [31:0] out_insn,
    output logic [29:0] out_pc,
    input  logic        out_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic          running_q;
    logic          busy_q;
    logic          discard_q;
    logic [CW-1:0] count_q;
    logic [PW-1:0] rd_q;
    logic [PW-1:0] wr_q;
    logic [29:0]   fetch_pc_q;
    logic [29:0]   req_pc_q;
    logic [31:0]   mem_insn_q [DEPTH];
    logic [29:0]   mem_pc_q   [DEPTH];

    logic push;
    logic pop;

    // busy is 0 whenever an issue is possible, so the credit check reduces to count alone
    assign insn_start = running_q && !busy_q && !flush && (count_q < DEPTH_C);
    assign insn_addr  = fetch_pc_q;

    assign out_valid  = (count_q != '0);
    assign out_insn   = mem_insn_q[rd_q];
    assign out_pc     = mem_pc_q[rd_q];

    always_comb begin
        push = busy_q && insn_ready && !discard_q && !flush;
        pop  = out_valid && out_ready && !flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_q  <= 1'b0;
            busy_q     <= 1'b0;
            discard_q  <= 1'b0;
            count_q    <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_insn_q[i] <= '0;
                mem_pc_q[i]   <= '0;
            end
        end else begin
            running_q <= 1'b1;
            if (flush) begin
                count_q    <= '0;
                rd_q       <= '0;
                wr_q       <= '0;
                fetch_pc_q <= target;
                if (busy_q && insn_ready) begin
                    busy_q    <= 1'b0;
                    discard_q <= 1'b0;
                end else if (busy_q) begin
                    discard_q <= 1'b1;
                end
            end else begin
                if (insn_start) begin
                    busy_q     <= 1'b1;
                    req_pc_q   <= fetch_pc_q;
                    fetch_pc_q <= fetch_pc_q + 30'd1;
                end
                // a response with nothing outstanding (e.g. left over from before reset) is ignored
                if (busy_q && insn_ready) begin
                    busy_q    <= 1'b0;
                    discard_q <= 1'b0;
                end
                if (push) begin
                    mem_insn_q[wr_q] <= insn_data_rd;
                    mem_pc_q[wr_q]   <= req_pc_q;
                    wr_q             <= wr_q + PW'(1);
                end
                if (pop) begin
                    rd_q <= rd_q + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_core_prefetch.sv
// Bench for core_prefetch: an MMU responder plus a transaction-level model feed an
// expected-output queue that an independent monitor checks on every decode pop.
module tb_core_prefetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic [29:0] target = '0;
    logic        insn_start;
    logic [29:0] insn_addr;
    logic        insn_ready = 1'b0;
    logic [31:0] insn_data_rd = '0;
    logic        out_valid;
    logic [31:0] out_insn;
    logic [29:0] out_pc;
    logic        out_ready = 1'b0;

    core_prefetch #(.DEPTH(4), .RESET_PC(30'h0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .target       (target),
        .insn_start   (insn_start),
        .insn_addr    (insn_addr),
        .insn_ready   (insn_ready),
        .insn_data_rd (insn_data_rd),
        .out_valid    (out_valid),
        .out_insn     (out_insn),
        .out_pc       (out_pc),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    int nchk  = 0;
    int nfail = 0;

    // reference model state
    logic [61:0] exp_q[$];
    logic [29:0] model_pc;
    logic        pending;
    logic        pend_disc;
    logic [29:0] pend_pc;
    logic [31:0] pend_data;
    int          lat;
    int          lat_fix;
    int          or_mode;
    logic        stale;
    int          nstarts;
    int          npops;
    logic        s_start;
    logic [29:0] s_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        nchk++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                chk("pop_with_nothing_expected", 1, 0);
            end else begin
                chk("out_pc", 64'(out_pc), 64'(exp_q[0][29:0]));
                chk("out_insn", 64'(out_insn), 64'(exp_q[0][61:30]));
                void'(exp_q.pop_front());
                npops++;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        insn_ready = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        model_pc = 30'h0;
        pending = 1'b0;
        pend_disc = 1'b0;
        stale = 1'b0;
        nstarts = 0;
        #1;
        chk("rst_insn_start", 64'(insn_start), 0);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_insn", 64'(out_insn), 0);
        chk("rst_out_pc", 64'(out_pc), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic tick(input logic f, input logic [29:0] t);
        logic was_pending;
        @(posedge clk);
        #1;
        flush = f;
        target = t;
        case (or_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (pending && lat == 0) begin
            insn_ready = 1'b1;
            insn_data_rd = pend_data;
        end else begin
            insn_ready = stale;
            insn_data_rd = $urandom;
        end
        stale = 1'b0;
        @(negedge clk);
        s_start = insn_start;
        s_addr = insn_addr;
        was_pending = pending;
        if (insn_ready && pending) begin
            pending = 1'b0;
            if (!pend_disc && !flush) exp_q.push_back({pend_data, pend_pc});
        end else if (pending && lat > 0) begin
            lat--;
        end
        if (flush) begin
            exp_q.delete();
            model_pc = target;
            if (pending) pend_disc = 1'b1;
            chk("no_start_in_flush", 64'(s_start), 0);
        end
        if (s_start) begin
            nstarts++;
            chk("single_outstanding", 64'(was_pending), 0);
            chk("insn_addr", 64'(s_addr), 64'(model_pc));
            pending = 1'b1;
            pend_disc = 1'b0;
            pend_pc = model_pc;
            model_pc = model_pc + 30'd1;
            pend_data = $urandom;
            lat = (lat_fix < 0) ? int'($urandom_range(0, 3)) : lat_fix;
        end
    endtask

    initial begin
        int guard;
        logic [29:0] a0, a1;
        #2;

        // sequential fetch with a 1-cycle MMU and decode always ready
        or_mode = 1; lat_fix = 0; npops = 0;
        do_reset();
        repeat (24) tick(0, 0);
        chk("t1_progress", 64'(npops >= 8), 1);

        // decode stalled: credit stops issue at DEPTH, one pop frees one start
        or_mode = 0; lat_fix = 0;
        do_reset();
        repeat (30) tick(0, 0);
        chk("t2_starts_full", 64'(nstarts), 4);
        chk("t2_start_held", 64'(s_start), 0);
        chk("t2_valid_full", 64'(out_valid), 1);
        or_mode = 1; tick(0, 0);
        or_mode = 0; repeat (6) tick(0, 0);
        chk("t2_starts_after_pop", 64'(nstarts), 5);

        // flush while busy: late response dropped, redirect after it
        or_mode = 1; lat_fix = 3;
        do_reset();
        guard = 0;
        while (!pending && guard < 20) begin tick(0, 0); guard++; end
        chk("t3_got_start", 64'(pending), 1);
        tick(1, 30'h100);
        guard = 0;
        while (pending && guard < 20) begin tick(0, 0); guard++; end
        chk("t3_response_came", 64'(pending), 0);
        tick(0, 0);
        chk("t3_valid_after_drop", 64'(out_valid), 0);
        chk("t3_start", 64'(s_start), 1);
        chk("t3_addr", 64'(s_addr), 64'(30'h100));

        // flush coinciding with insn_ready while queue holds 3
        or_mode = 0; lat_fix = 0;
        do_reset();
        guard = 0;
        while (nstarts < 4 && guard < 40) begin tick(0, 0); guard++; end
        chk("t4_starts", 64'(nstarts), 4);
        chk("t4_valid_before", 64'(out_valid), 1);
        tick(1, 30'h2A5);
        tick(0, 0);
        chk("t4_valid_after", 64'(out_valid), 0);
        chk("t4_start", 64'(s_start), 1);
        chk("t4_addr", 64'(s_addr), 64'(30'h2A5));

        // PC wrap at the top of the address space
        or_mode = 1; lat_fix = 0;
        do_reset();
        tick(1, 30'h3FFFFFFF);
        nstarts = 0; a0 = '1; a1 = '1; guard = 0;
        while (nstarts < 2 && guard < 20) begin
            tick(0, 0);
            if (s_start && nstarts == 1) a0 = s_addr;
            if (s_start && nstarts == 2) a1 = s_addr;
            guard++;
        end
        chk("t5_addr_top", 64'(a0), 64'(30'h3FFFFFFF));
        chk("t5_addr_wrap", 64'(a1), 0);
        repeat (6) tick(0, 0);

        // reset mid-fetch with queue non-empty, then a stale response
        or_mode = 0; lat_fix = 2;
        do_reset();
        guard = 0;
        while (!(exp_q.size() >= 2 && pending) && guard < 40) begin tick(0, 0); guard++; end
        chk("t6_setup", 64'(exp_q.size() >= 2 && pending), 1);
        @(posedge clk);
        #1;
        or_mode = 1; lat_fix = 0;
        do_reset();
        stale = 1'b1;
        tick(0, 0);
        tick(0, 0);
        chk("t6_stale_ignored", 64'(out_valid), 0);
        nstarts = 0; a0 = '1;
        do_reset();
        guard = 0;
        while (nstarts < 1 && guard < 10) begin tick(0, 0); guard++; end
        a0 = s_addr;
        chk("t6_first_start", 64'(nstarts), 1);
        chk("t6_first_addr", 64'(a0), 0);

        // randomized traffic: random latency, decode stalls and redirects
        or_mode = 2; lat_fix = -1; npops = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) tick(1, 30'($urandom));
            else tick(0, 0);
        end
        chk("random_progress", 64'(npops > 200), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
